// File: rtl/act_mem_loader.sv
// Streams ENTRY_NUM*DIM*DIM words into activation memory, x fastest, then y, then entry.
// Optional macro ACT_MEM_LOADER_ABORT_EN adds an abort input that cancels a load in progress.
module act_mem_loader #(
  parameter int ENTRY_NUM = 16,
  parameter int DIM       = 1,
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
`ifdef ACT_MEM_LOADER_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 in_ready,
  output logic                 mem_write,
  output logic [15:0]          mem_index_entry,
  output logic [15:0]          mem_index_y,
  output logic [15:0]          mem_index_x,
  output logic [DATA_SIZE-1:0] mem_in_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [15:0] ENTRY_LAST = 16'(ENTRY_NUM - 1);
  localparam logic [15:0] DIM_LAST   = 16'(DIM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                 state, state_nxt;
  logic [15:0]            x_cnt, y_cnt, e_cnt;
  logic                   accept;
  logic                   abort_req;
  logic                   vld_p1;
  logic [15:0]            entry_p1, y_p1, x_p1;
  logic [DATA_SIZE-1:0]   data_p1;

`ifdef ACT_MEM_LOADER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic is_last(input logic [15:0] e, input logic [15:0] y,
                                   input logic [15:0] x);
    return (e == ENTRY_LAST) && (y == DIM_LAST) && (x == DIM_LAST);
  endfunction

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (abort_req) begin
          state_nxt = IDLE;
        end else begin
          in_ready = 1'b1;
          if (in_valid && is_last(e_cnt, y_cnt, x_cnt)) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Stage p0 -> p1: capture the accepted beat with the address it was accepted at.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_cnt    <= '0;
      y_cnt    <= '0;
      e_cnt    <= '0;
      vld_p1   <= 1'b0;
      entry_p1 <= '0;
      y_p1     <= '0;
      x_p1     <= '0;
      data_p1  <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= accept;
      if (state == IDLE && start) begin
        x_cnt <= '0;
        y_cnt <= '0;
        e_cnt <= '0;
      end else if (accept) begin
        data_p1  <= in_data;
        entry_p1 <= e_cnt;
        y_p1     <= y_cnt;
        x_p1     <= x_cnt;
        if (x_cnt == DIM_LAST) begin
          x_cnt <= '0;
          if (y_cnt == DIM_LAST) begin
            y_cnt <= '0;
            e_cnt <= e_cnt + 16'd1;
          end else begin
            y_cnt <= y_cnt + 16'd1;
          end
        end else begin
          x_cnt <= x_cnt + 16'd1;
        end
      end
    end
  end

  assign mem_write       = vld_p1;
  assign mem_index_entry = entry_p1;
  assign mem_index_y     = y_p1;
  assign mem_index_x     = x_p1;
  assign mem_in_data     = data_p1;

endmodule

// File: doc/act_mem_loader.md
ACT_MEM_LOADER -- requirements
Module: act_mem_loader

Interface
- REQ-001 Parameter ENTRY_NUM, default 16, number of activation entries to fill.
- REQ-002 Parameter DIM, default 1, side length of each square activation map.
- REQ-003 Parameter DATA_SIZE, default 64, word width (IEEE-754 double bit pattern).
- REQ-004 clk  input  1  sole clock; all state updates on rising edge.
- REQ-005 rst  input  1  reset, synchronous, active-high.
- REQ-006 start  input  1  begin a load when in IDLE.
- REQ-007 in_valid  input  1  upstream word present.
- REQ-008 in_data  input  DATA_SIZE  upstream word.
- REQ-009 in_ready  output  1  loader accepts word this cycle.
- REQ-010 mem_write  output  1  write strobe to activation memory.
- REQ-011 mem_index_entry, mem_index_y, mem_index_x  output  16 each  write address.
- REQ-012 mem_in_data  output  DATA_SIZE  write data.
- REQ-013 busy  output  1  high while in LOAD.
- REQ-014 done  output  1  one-cycle pulse after last word is written.

Function
- REQ-015 FSM states: IDLE, LOAD, DONE.
- REQ-016 IDLE -> LOAD on start; x, y, entry counters cleared to 0 on that edge.
- REQ-017 In LOAD, in_ready SHALL be 1; in all other states it SHALL be 0.
- REQ-018 Beat accepted when in_valid && in_ready; no other condition advances counters.
- REQ-019 An accepted beat SHALL produce mem_write=1 exactly one cycle later, with registered data and the counter values at acceptance.
- REQ-020 mem_write SHALL be 0 in every cycle not following an accepted beat.
- REQ-021 Address order x fastest, then y, then entry: x wraps DIM-1 -> 0 incrementing y; y wraps DIM-1 -> 0 incrementing entry.
- REQ-022 Beat at (ENTRY_NUM-1, DIM-1, DIM-1) is the last; FSM moves LOAD -> DONE on its acceptance edge.
- REQ-023 DONE lasts one cycle, in which done=1 and the last mem_write is asserted; then -> IDLE.
- REQ-024 start while in LOAD or DONE SHALL be ignored.
- REQ-025 in_valid low in LOAD stalls without limit; counters hold.
- REQ-026 Counters and indices are 16-bit; ENTRY_NUM and DIM SHALL each be at most 65535.
- REQ-027 Total beats per load SHALL equal ENTRY_NUM*DIM*DIM exactly.
- REQ-028 With DIM=1, every beat SHALL increment entry; x and y stay 0.

Reset
- REQ-029 On rst high at a clock edge: state=IDLE, counters=0, mem_write=0, in_ready=0, busy=0, done=0, indices=0, mem_in_data=0.
- REQ-030 rst during LOAD SHALL abandon the load; no mem_write is issued on the following cycle, even for a beat accepted on the reset edge.
- REQ-031 rst has priority over start and in_valid.

Configuration
- REQ-032 Macro ACT_MEM_LOADER_ABORT_EN, when defined, adds input port abort (1 bit).
- REQ-033 With the macro defined: abort high in LOAD forces in_ready=0 that cycle and moves the FSM to IDLE next edge without a done pulse. A write for a beat accepted the previous cycle still completes. Counters are left unchanged until the next start.
- REQ-034 With the macro undefined: no abort port exists and behaviour is REQ-015..REQ-031 only.

Verification
- REQ-035 ENTRY_NUM=2, DIM=2; start, then 8 back-to-back beats 1.0..8.0 -> writes to (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)..(1,1,1) with matching data, each 1 cycle after acceptance; done pulses once with the 8th write.
- REQ-036 Same configuration, in_valid toggled 1/0 each cycle -> still exactly 8 writes in the same order; busy stays high for 15 cycles.
- REQ-037 DIM=1, ENTRY_NUM=3; 3 beats -> entries 0,1,2 with x=y=0; done pulses on the 3rd write.
- REQ-038 rst asserted after 3 of 8 beats -> no further mem_write; in_ready=0, busy=0; a new start then begins again at (0,0,0).
- REQ-039 start pulsed mid-load, and in_valid high while IDLE -> no effect: in_ready=0 in IDLE, no extra writes, order unchanged.
- REQ-040 ACT_MEM_LOADER_ABORT_EN defined; abort after 5 beats -> 5 writes only, no done pulse, IDLE next cycle.
